// File: rtl/tpu_serial_loader.sv
// Serial-to-parallel operand loader: X/Y bits arrive MSB-first, word 0 first, and assemble into N*D_W frames.
// A frame appears on mat_x/mat_y one edge after its last sample and is held until mat_ready; a frame completing behind an unaccepted one is dropped (overrun).
module tpu_serial_loader #(
   parameter int D_W = 8,
   parameter int N   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_in_x,
   input  logic             data_in_y,
   input  logic             load_en,
   input  logic             init,
   output logic [N*D_W-1:0] mat_x,
   output logic [N*D_W-1:0] mat_y,
   output logic             mat_valid,
   input  logic             mat_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int FW  = N * D_W;
   localparam int BCW = (D_W > 1) ? $clog2(D_W) : 1;
   localparam int WCW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic [FW-1:0]  asm_x_q, asm_x_d;
   logic [FW-1:0]  asm_y_q, asm_y_d;
   logic           last_bit;
   logic           last_word;
   logic           frame_done;
   logic           accept;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      asm_x_d    = asm_x_q;
      asm_y_d    = asm_y_q;
      last_bit   = (bit_cnt_q == BCW'(D_W - 1));
      last_word  = (word_cnt_q == WCW'(N - 1));
      frame_done = load_en && last_bit && last_word && !init;
      accept     = mat_valid && mat_ready;

      // Bit b of word w (b counts samples, so b=0 is the word's MSB).
      for (int w = 0; w < N; w++) begin
         for (int b = 0; b < D_W; b++) begin
            if (load_en && word_cnt_q == WCW'(w) && bit_cnt_q == BCW'(b)) begin
               asm_x_d[w*D_W + D_W - 1 - b] = data_in_x;
               asm_y_d[w*D_W + D_W - 1 - b] = data_in_y;
            end
         end
      end

      if (init) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         asm_x_d    = '0;
         asm_y_d    = '0;
      end else if (load_en) begin
         if (last_bit) begin
            bit_cnt_d  = '0;
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
         state_d = frame_done ? IDLE : SHIFT;
      end
   end

   assign busy = (state_q == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         asm_x_q    <= '0;
         asm_y_q    <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         asm_x_q    <= asm_x_d;
         asm_y_q    <= asm_y_d;
      end
   end

   // Holding registers: a frame completing in the acceptance cycle replaces the outgoing one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mat_x     <= '0;
         mat_y     <= '0;
         mat_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (init) begin
         mat_x     <= '0;
         mat_y     <= '0;
         mat_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (frame_done) begin
         if (!mat_valid || mat_ready) begin
            mat_x     <= asm_x_d;
            mat_y     <= asm_y_d;
            mat_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (accept) begin
         mat_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tpu_serial_loader.sv
// Bench for tpu_serial_loader: directed frame scenarios plus random traffic against a sample-count reference model.
module tb_tpu_serial_loader;

   localparam int D_W = 8;
   localparam int N   = 2;
   localparam int FW  = N * D_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          data_in_x = 1'b0;
   logic          data_in_y = 1'b0;
   logic          load_en = 1'b0;
   logic          init = 1'b0;
   logic          mat_ready = 1'b0;
   logic [FW-1:0] mat_x;
   logic [FW-1:0] mat_y;
   logic          mat_valid;
   logic          busy;
   logic          overrun;

   tpu_serial_loader #(.D_W(D_W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in_x (data_in_x),
      .data_in_y (data_in_y),
      .load_en   (load_en),
      .init      (init),
      .mat_x     (mat_x),
      .mat_y     (mat_y),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: count samples, place each by arithmetic, track the single holding slot.
   int            m_nbits = 0;
   logic [FW-1:0] m_fx = '0, m_fy = '0;
   logic          m_valid = 1'b0;
   logic          m_ovr = 1'b0;
   logic [FW-1:0] m_x = '0, m_y = '0;
   logic [2*FW-1:0] sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_nbits = 0;
      m_fx = '0;
      m_fy = '0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_x = '0;
      m_y = '0;
      sbq.delete();
   endtask

   task automatic model_edge(input logic bx, input logic by, input logic le,
                             input logic rdy, input logic ini);
      bit done;
      int w, b;
      if (ini) begin
         model_clear();
         return;
      end
      done = 0;
      if (le) begin
         w = m_nbits / D_W;
         b = m_nbits % D_W;
         m_fx[w*D_W + D_W - 1 - b] = bx;
         m_fy[w*D_W + D_W - 1 - b] = by;
         m_nbits++;
         if (m_nbits == FW) begin
            done = 1;
            m_nbits = 0;
         end
      end
      if (m_valid && rdy) m_valid = 1'b0;
      if (done) begin
         if (m_valid) begin
            m_ovr = 1'b1;
         end else begin
            m_valid = 1'b1;
            m_x = m_fx;
            m_y = m_fy;
            sbq.push_back({m_fx, m_fy});
         end
         m_fx = '0;
         m_fy = '0;
      end
   endtask

   // Called at posedge+1; drives inputs for the coming edge, then checks status one step after it.
   task automatic cycle(input logic bx, input logic by, input logic le,
                        input logic rdy, input logic ini);
      data_in_x = bx;
      data_in_y = by;
      load_en   = le;
      mat_ready = rdy;
      init      = ini;
      @(posedge clk);
      model_edge(bx, by, le, rdy, ini);
      #1;
      chk("valid", 32'(mat_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_nbits != 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) begin
         chk("hold_x", 32'(mat_x), 32'(m_x));
         chk("hold_y", 32'(mat_y), 32'(m_y));
      end
   endtask

   task automatic send_frame(input logic [FW-1:0] fx, input logic [FW-1:0] fy,
                             input logic rdy_last, input int gap_at, input int gap_len);
      int p;
      for (int i = 0; i < FW; i++) begin
         p = (i / D_W) * D_W + D_W - 1 - (i % D_W);
         cycle(fx[p], fy[p], 1'b1, (i == FW - 1) ? rdy_last : 1'b0, 1'b0);
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
               chk("gap_busy", 32'(busy), 32'd1);
            end
         end
      end
   endtask

   // Scoreboard monitor: every handshake must deliver the oldest loaded frame.
   always @(negedge clk) begin
      logic [2*FW-1:0] e;
      if (rst_n && mat_valid && mat_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_frame", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_x", 32'(mat_x), 32'(e[2*FW-1:FW]));
            chk("sb_y", 32'(mat_y), 32'(e[FW-1:0]));
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_valid", 32'(mat_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_x", 32'(mat_x), 32'd0);
      chk("rst_y", 32'(mat_y), 32'd0);

      // Basic frame, consumer stalled.
      send_frame(16'h3CA5, 16'h8001, 1'b0, -1, 0);
      chk("f1_valid", 32'(mat_valid), 32'd1);
      chk("f1_x", 32'(mat_x), 32'h3CA5);
      chk("f1_y", 32'(mat_y), 32'h8001);
      chk("f1_busy", 32'(busy), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("f1_accepted", 32'(mat_valid), 32'd0);

      // Same frame with a load_en gap after the third bit.
      send_frame(16'h3CA5, 16'h8001, 1'b0, 2, 5);
      chk("gap_x", 32'(mat_x), 32'h3CA5);
      chk("gap_y", 32'(mat_y), 32'h8001);

      // Second frame completes behind the held one: dropped.
      send_frame(16'h1122, 16'h3344, 1'b0, -1, 0);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_x", 32'(mat_x), 32'h3CA5);
      chk("ovr_y", 32'(mat_y), 32'h8001);

      // init after 9 samples while a frame is held.
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("init_valid", 32'(mat_valid), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_x", 32'(mat_x), 32'd0);
      chk("init_ovr", 32'(overrun), 32'd0);
      send_frame(16'h3CA5, 16'h8001, 1'b0, -1, 0);
      chk("post_init_x", 32'(mat_x), 32'h3CA5);
      chk("post_init_y", 32'(mat_y), 32'h8001);

      // New frame completes in the acceptance cycle.
      send_frame(16'h1122, 16'h3344, 1'b1, -1, 0);
      chk("swap_valid", 32'(mat_valid), 32'd1);
      chk("swap_x", 32'(mat_x), 32'h1122);
      chk("swap_y", 32'(mat_y), 32'h3344);
      chk("swap_ovr", 32'(overrun), 32'd0);

      // Asynchronous reset between edges, mid-frame.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      load_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(mat_valid), 32'd0);
      chk("arst_x", 32'(mat_x), 32'd0);
      chk("arst_y", 32'(mat_y), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      model_clear();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_frame(16'h3CA5, 16'h8001, 1'b0, -1, 0);
      chk("post_rst_x", 32'(mat_x), 32'h3CA5);
      chk("post_rst_y", 32'(mat_y), 32'h8001);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 249) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
